// File: rtl/display_scan_ctrl.sv
// Scan scheduler for a 5-digit multiplexed 7-segment display: frame snapshot,
// per-slot blanking + 16-step PWM, leading-zero suppression and digit blink.
module display_scan_ctrl #(
    parameter int TICK_DIV     = 1000,
    parameter int BLANK_TICKS  = 2,
    parameter int BLINK_FRAMES = 555
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [19:0] digits,
    input  logic [4:0]  dp_mask,
    input  logic [4:0]  blink_mask,
    input  logic [3:0]  brightness,
    input  logic        lz_enable,
    output logic [2:0]  digit_sel,
    output logic [3:0]  digit_val,
    output logic        dp,
    output logic        blank,
    output logic [4:0]  cathodes,
    output logic        frame_tick
);

    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int BTW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
    localparam int SW  = (BTW > 4) ? BTW : 4;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    // Handshake-free block: all inputs are sampled into the snapshot, never acknowledged.
    logic [PW-1:0] pre;
    logic          tick;

    state_t        state, state_nxt;
    logic [SW-1:0] sub, sub_nxt;
    logic [2:0]    sel_nxt;
    logic          frame_end;

    logic          snap_pending;
    logic          take_snap;
    logic [19:0]   s_digits, s_digits_nxt;
    logic [4:0]    s_dpm, s_dpm_nxt;
    logic [4:0]    s_bm, s_bm_nxt;
    logic [3:0]    s_br, s_br_nxt;
    logic          s_lz, s_lz_nxt;

    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic          blink_phase, blink_phase_nxt;

    logic [4:0]    upper_zero;
    logic          supp;
    logic          lit;
    logic [4:0]    cath_nxt;
    logic [3:0]    val_nxt;
    logic          dp_nxt;

    // With TICK_DIV=1 the counter sits at 0 and tick is permanently high.
    assign tick = (pre == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        sub_nxt   = sub;
        sel_nxt   = digit_sel;
        frame_end = 1'b0;
        if (tick) begin
            case (state)
                ST_BLANK: begin
                    if (sub == SW'(BLANK_TICKS - 1)) begin
                        state_nxt = ST_ON;
                        sub_nxt   = '0;
                    end else begin
                        sub_nxt = sub + SW'(1);
                    end
                end
                ST_ON: begin
                    if (sub == SW'(15)) begin
                        state_nxt = ST_BLANK;
                        sub_nxt   = '0;
                        if (digit_sel == 3'd4) begin
                            sel_nxt   = 3'd0;
                            frame_end = 1'b1;
                        end else begin
                            sel_nxt = digit_sel + 3'd1;
                        end
                    end else begin
                        sub_nxt = sub + SW'(1);
                    end
                end
                default: begin
                    state_nxt = ST_BLANK;
                    sub_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        take_snap    = snap_pending | frame_end;
        s_digits_nxt = take_snap ? digits     : s_digits;
        s_dpm_nxt    = take_snap ? dp_mask    : s_dpm;
        s_bm_nxt     = take_snap ? blink_mask : s_bm;
        s_br_nxt     = take_snap ? brightness : s_br;
        s_lz_nxt     = take_snap ? lz_enable  : s_lz;

        blink_cnt_nxt   = blink_cnt;
        blink_phase_nxt = blink_phase;
        if (frame_end) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_nxt   = '0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                blink_cnt_nxt = blink_cnt + BW'(1);
            end
        end
    end

    // Outputs are derived from the post-edge values so they stay aligned with the FSM.
    always_comb begin
        upper_zero    = '0;
        upper_zero[4] = (s_digits_nxt[19:16] == 4'd0);
        for (int i = 3; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (s_digits_nxt[i*4 +: 4] == 4'd0);
        end
        supp = (s_lz_nxt && (sel_nxt != 3'd0) && upper_zero[sel_nxt])
            || (blink_phase_nxt && s_bm_nxt[sel_nxt]);
        lit      = (state_nxt == ST_ON) && (sub_nxt < SW'(s_br_nxt)) && !supp;
        cath_nxt = lit ? (5'b00001 << sel_nxt) : 5'b00000;
        val_nxt  = s_digits_nxt[{sel_nxt, 2'b00} +: 4];
        dp_nxt   = s_dpm_nxt[sel_nxt] & ~supp;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_BLANK;
            sub          <= '0;
            snap_pending <= 1'b1;
            s_digits     <= '0;
            s_dpm        <= '0;
            s_bm         <= '0;
            s_br         <= '0;
            s_lz         <= 1'b0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            digit_sel    <= 3'd0;
            digit_val    <= 4'd0;
            dp           <= 1'b0;
            blank        <= 1'b1;
            cathodes     <= 5'b00000;
            frame_tick   <= 1'b0;
        end else begin
            state        <= state_nxt;
            sub          <= sub_nxt;
            snap_pending <= 1'b0;
            s_digits     <= s_digits_nxt;
            s_dpm        <= s_dpm_nxt;
            s_bm         <= s_bm_nxt;
            s_br         <= s_br_nxt;
            s_lz         <= s_lz_nxt;
            blink_cnt    <= blink_cnt_nxt;
            blink_phase  <= blink_phase_nxt;
            digit_sel    <= sel_nxt;
            digit_val    <= val_nxt;
            dp           <= dp_nxt;
            blank        <= ~|cath_nxt;
            cathodes     <= cath_nxt;
            frame_tick   <= frame_end;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with TICK_DIV=1, BLANK_TICKS=2, BLINK_FRAMES=2:
// each frame is logged cycle by cycle and summarised per slot.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [19:0] digits = '0;
    logic [4:0]  dp_mask = '0;
    logic [4:0]  blink_mask = '0;
    logic [3:0]  brightness = '0;
    logic        lz_enable = 1'b0;
    logic [2:0]  digit_sel;
    logic [3:0]  digit_val;
    logic        dp;
    logic        blank;
    logic [4:0]  cathodes;
    logic        frame_tick;

    int n_pass  = 0;
    int n_total = 0;

    logic [4:0] cath_log [90];
    logic [3:0] val_log  [90];
    logic [2:0] sel_log  [90];
    logic       dp_log   [90];
    logic       ft_log   [90];
    logic       blank_log[90];

    int         on_cnt  [5];
    int         bad_cath[5];
    int         first_on[5];
    logic [3:0] on_val  [5];
    int         val_bad [5];
    int         dp_cnt  [5];
    int         sel_bad [5];
    int         blank_bad;
    int         ft_cnt;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .TICK_DIV    (1),
        .BLANK_TICKS (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .digits    (digits),
        .dp_mask   (dp_mask),
        .blink_mask(blink_mask),
        .brightness(brightness),
        .lz_enable (lz_enable),
        .digit_sel (digit_sel),
        .digit_val (digit_val),
        .dp        (dp),
        .blank     (blank),
        .cathodes  (cathodes),
        .frame_tick(frame_tick)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Logs 90 negedge samples starting at the current one and leaves time at the
    // negedge that starts the following frame.
    task automatic run_frame(input int chg_cyc, input logic [19:0] chg_val);
        for (int k = 0; k < 90; k++) begin
            cath_log[k]  = cathodes;
            val_log[k]   = digit_val;
            sel_log[k]   = digit_sel;
            dp_log[k]    = dp;
            ft_log[k]    = frame_tick;
            blank_log[k] = blank;
            if (k == chg_cyc) digits = chg_val;
            @(negedge clk);
        end
        for (int s = 0; s < 5; s++) begin
            on_cnt[s] = 0; bad_cath[s] = 0; first_on[s] = -1; on_val[s] = 4'd0;
            val_bad[s] = 0; dp_cnt[s] = 0; sel_bad[s] = 0;
        end
        blank_bad = 0;
        ft_cnt    = 0;
        for (int k = 0; k < 90; k++) begin
            int s;
            int o;
            s = k / 18;
            o = k % 18;
            if (sel_log[k] != 3'(s)) sel_bad[s]++;
            if (cath_log[k] != 5'd0) begin
                if (cath_log[k] == (5'b00001 << s)) begin
                    on_cnt[s]++;
                    if (first_on[s] < 0) begin
                        first_on[s] = o;
                        on_val[s]   = val_log[k];
                    end else if (val_log[k] != on_val[s]) begin
                        val_bad[s]++;
                    end
                end else begin
                    bad_cath[s]++;
                end
            end
            if (o >= 2 && dp_log[k]) dp_cnt[s]++;
            if (blank_log[k] != (cath_log[k] == 5'd0)) blank_bad++;
            if (ft_log[k]) ft_cnt++;
        end
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (frame_tick !== 1'b1) $display("FAIL wait_frame: frame_tick=%b after %0d cycles, want 1", frame_tick, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; digits = 20'h12345; dp_mask = 5'b00000; blink_mask = 5'b00000;
        brightness = 4'd15; lz_enable = 1'b0;
        #12;
        n_total++; if (digit_sel !== 3'd0) $display("FAIL rst_sel: got %0d want 0", digit_sel); else n_pass++;
        n_total++; if (digit_val !== 4'd0) $display("FAIL rst_val: got %0h want 0", digit_val); else n_pass++;
        n_total++; if (dp !== 1'b0) $display("FAIL rst_dp: got %b want 0", dp); else n_pass++;
        n_total++; if (blank !== 1'b1) $display("FAIL rst_blank: got %b want 1", blank); else n_pass++;
        n_total++; if (cathodes !== 5'd0) $display("FAIL rst_cath: got %b want 00000", cathodes); else n_pass++;
        n_total++; if (frame_tick !== 1'b0) $display("FAIL rst_ft: got %b want 0", frame_tick); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_total++; if (cathodes !== 5'd0) $display("FAIL rel_blank_cath: got %b want 00000", cathodes); else n_pass++;
        n_total++; if (digit_sel !== 3'd0) $display("FAIL rel_sel: got %0d want 0", digit_sel); else n_pass++;
        n_total++; if (digit_val !== 4'd5) $display("FAIL rel_snapshot_val: got %0h want 5", digit_val); else n_pass++;
        @(negedge clk);
        n_total++; if (cathodes !== 5'b00001) $display("FAIL rel_first_on: got %b want 00001", cathodes); else n_pass++;
        n_total++; if (blank !== 1'b0) $display("FAIL rel_first_on_blank: got %b want 0", blank); else n_pass++;
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (cathodes !== 5'b00100 && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_total++; if (cathodes !== 5'b00100) $display("FAIL reach_slot2_on: got %b want 00100", cathodes); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (cathodes !== 5'd0) $display("FAIL async_rst_cath: got %b want 00000", cathodes); else n_pass++;
        n_total++; if (blank !== 1'b1) $display("FAIL async_rst_blank: got %b want 1", blank); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_scan_timing();
        logic [3:0] exp_val [5];
        exp_val = '{4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        digits = 20'h12345; dp_mask = 5'b00100; brightness = 4'd15; lz_enable = 1'b0;
        wait_frame();
        run_frame(-1, 20'h0);
        n_total++; if (cath_log[17] !== 5'd0) $display("FAIL scan_slot0_tail: got %b want 00000", cath_log[17]); else n_pass++;
        n_total++; if (cath_log[1] !== 5'd0) $display("FAIL scan_slot0_blank1: got %b want 00000", cath_log[1]); else n_pass++;
        for (int s = 0; s < 5; s++) begin
            n_total++; if (on_cnt[s] != 15) $display("FAIL scan_on_cnt[%0d]: got %0d want 15", s, on_cnt[s]); else n_pass++;
            n_total++; if (first_on[s] != 2) $display("FAIL scan_first_on[%0d]: got %0d want 2", s, first_on[s]); else n_pass++;
            n_total++; if (on_val[s] !== exp_val[s]) $display("FAIL scan_val[%0d]: got %0h want %0h", s, on_val[s], exp_val[s]); else n_pass++;
            n_total++; if (val_bad[s] + bad_cath[s] + sel_bad[s] != 0) $display("FAIL scan_slot_clean[%0d]: got %0d bad cycles want 0", s, val_bad[s] + bad_cath[s] + sel_bad[s]); else n_pass++;
            n_total++; if (dp_cnt[s] != ((s == 2) ? 16 : 0)) $display("FAIL scan_dp[%0d]: got %0d want %0d", s, dp_cnt[s], (s == 2) ? 16 : 0); else n_pass++;
        end
        n_total++; if (blank_bad != 0) $display("FAIL scan_blank_vs_cath: got %0d bad cycles want 0", blank_bad); else n_pass++;
        n_total++; if (ft_log[0] !== 1'b1 || ft_cnt != 1) $display("FAIL scan_ft_frame1: got first=%b count=%0d want 1/1", ft_log[0], ft_cnt); else n_pass++;
        run_frame(-1, 20'h0);
        n_total++; if (ft_log[0] !== 1'b1 || ft_cnt != 1) $display("FAIL scan_ft_period90: got first=%b count=%0d want 1/1", ft_log[0], ft_cnt); else n_pass++;
    endtask

    task automatic test_brightness();
        dp_mask = 5'b00000; brightness = 4'd0;
        wait_frame();
        for (int f = 0; f < 3; f++) begin
            run_frame(-1, 20'h0);
            n_total++;
            if (on_cnt[0] + on_cnt[1] + on_cnt[2] + on_cnt[3] + on_cnt[4] + bad_cath[0] + bad_cath[1] + bad_cath[2] + bad_cath[3] + bad_cath[4] != 0)
                $display("FAIL bright0_frame%0d: got nonzero cathodes want none", f);
            else n_pass++;
        end
        brightness = 4'd4;
        wait_frame();
        run_frame(-1, 20'h0);
        for (int s = 0; s < 5; s++) begin
            n_total++; if (on_cnt[s] != 4 || first_on[s] != 2) $display("FAIL bright4[%0d]: got %0d on from %0d want 4 from 2", s, on_cnt[s], first_on[s]); else n_pass++;
        end
    endtask

    task automatic test_leading_zeros();
        digits = 20'h00070; brightness = 4'd15; lz_enable = 1'b1;
        wait_frame();
        run_frame(-1, 20'h0);
        for (int s = 2; s < 5; s++) begin
            n_total++; if (on_cnt[s] + bad_cath[s] != 0) $display("FAIL lz_suppressed[%0d]: got %0d on want 0", s, on_cnt[s]); else n_pass++;
        end
        n_total++; if (on_cnt[1] != 15 || on_val[1] !== 4'h7) $display("FAIL lz_slot1: got %0d on val %0h want 15 val 7", on_cnt[1], on_val[1]); else n_pass++;
        n_total++; if (on_cnt[0] != 15 || on_val[0] !== 4'h0) $display("FAIL lz_slot0: got %0d on val %0h want 15 val 0", on_cnt[0], on_val[0]); else n_pass++;
        lz_enable = 1'b0;
        wait_frame();
        run_frame(-1, 20'h0);
        for (int s = 0; s < 5; s++) begin
            n_total++; if (on_cnt[s] != 15) $display("FAIL lz_off[%0d]: got %0d on want 15", s, on_cnt[s]); else n_pass++;
        end
    endtask

    task automatic test_non_bcd();
        logic [3:0] exp_val [5];
        exp_val = '{4'h9, 4'hB, 4'hF, 4'h0, 4'hA};
        digits = 20'hA0FB9; lz_enable = 1'b1;
        wait_frame();
        run_frame(-1, 20'h0);
        for (int s = 0; s < 5; s++) begin
            n_total++; if (on_cnt[s] != 15 || on_val[s] !== exp_val[s]) $display("FAIL nonbcd[%0d]: got %0d on val %0h want 15 val %0h", s, on_cnt[s], on_val[s], exp_val[s]); else n_pass++;
        end
        lz_enable = 1'b0;
    endtask

    task automatic test_snapshot();
        digits = 20'h11111;
        wait_frame();
        run_frame(40, 20'h22222);
        for (int s = 2; s < 5; s++) begin
            n_total++; if (on_val[s] !== 4'h1 || val_bad[s] != 0) $display("FAIL snap_frameN[%0d]: got %0h want 1", s, on_val[s]); else n_pass++;
        end
        run_frame(-1, 20'h0);
        for (int s = 0; s < 5; s++) begin
            n_total++; if (on_val[s] !== 4'h2) $display("FAIL snap_frameN1[%0d]: got %0h want 2", s, on_val[s]); else n_pass++;
        end
    endtask

    task automatic test_blink();
        digits = 20'h12345; dp_mask = 5'b11111; blink_mask = 5'b00011; brightness = 4'd15; lz_enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int f = 0; f < 6; f++) begin
            run_frame(-1, 20'h0);
            for (int s = 0; s < 5; s++) begin
                bit lit_exp;
                lit_exp = !((f == 2 || f == 3) && s < 2);
                n_total++; if (on_cnt[s] != (lit_exp ? 15 : 0)) $display("FAIL blink_on f%0d s%0d: got %0d want %0d", f, s, on_cnt[s], lit_exp ? 15 : 0); else n_pass++;
                n_total++; if (dp_cnt[s] != (lit_exp ? 16 : 0)) $display("FAIL blink_dp f%0d s%0d: got %0d want %0d", f, s, dp_cnt[s], lit_exp ? 16 : 0); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_scan_timing();
        test_brightness();
        test_leading_zeros();
        test_non_bcd();
        test_snapshot();
        test_blink();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
